// File: rtl/tcp_vlg_pkg.sv
// tcp_vlg_pkg
// Shared types for the TCP transmit path: the per-packet info record held in
// the TX packet-info RAM, the scanner FSM state encoding, and the sequence-space
// acknowledgement helper.
//
// No ports (package).

package tcp_vlg_pkg;

    // Width of the time stamp stored in each packet-info record. The scanner's
    // TIME_W parameter must match this so write-backs of the time base fit.
    localparam int PKT_TIME_W = 16;

    // One entry of the TX packet-info ring.
    typedef struct packed {
        logic                  present;
        logic [31:0]           seq;
        logic [15:0]           length;
        logic [PKT_TIME_W-1:0] tim;
        logic [3:0]            tries;
    } tcp_pkt_t;

    // Scanner FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_EVAL,
        ST_RTX,
        ST_WRITE,
        ST_FREE,
        ST_NEXT
    } scan_state_t;

    // An entry is covered by the remote ack when ackNum is at or beyond the
    // end of the entry in modular sequence space. The sign bit of the 32-bit
    // difference gives the right answer across sequence-number wrap.
    function automatic logic isAcked(input logic [31:0] ackNum, input tcp_pkt_t pkt);
        logic [31:0] ackDiff;
        ackDiff = ackNum - (pkt.seq + {16'b0, pkt.length});
        return ~ackDiff[31];
    endfunction

endpackage

// File: rtl/tcp_vlg_tx_timer.sv
// tcp_vlg_tx_timer
// Free-running retransmission time base and the expiry compare for the entry
// currently held by the scanner.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   tick_i     time-base strobe, advances now_o by one
//   tim_i      time stamp of the entry under evaluation
//   now_o      current time base value (wraps freely)
//   expired_o  (now_o - tim_i) mod 2^TIME_W >= RTO

module tcp_vlg_tx_timer #(
    parameter int TIME_W = 16,
    parameter int RTO    = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic [TIME_W-1:0] tim_i,
    output logic [TIME_W-1:0] now_o,
    output logic              expired_o
);

    logic [TIME_W-1:0] now_q;
    logic [TIME_W-1:0] now_d;
    logic [TIME_W-1:0] elapsed;

    // The time base only moves on tick strobes and is allowed to wrap; the
    // elapsed-time subtraction below is modular so wrap is harmless.
    always_comb begin
        now_d = now_q;
        if (tick_i) begin
            now_d = now_q + TIME_W'(1);
        end
    end

    // Time base register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_q <= '0;
        end else begin
            now_q <= now_d;
        end
    end

    assign elapsed   = now_q - tim_i;
    assign expired_o = (elapsed >= TIME_W'(RTO));
    assign now_o     = now_q;

endmodule

// File: rtl/tcp_vlg_tx_scan.sv
// tcp_vlg_tx_scan
// Scanning controller for the TCP transmit packet-info RAM. Walks the occupied
// ring entries from head to tail, frees entries covered by the remote ack (only
// contiguously from the head), requests retransmission of entries whose timer
// has expired, and writes updated entry state back through RAM port B.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                connection established; scanning allowed only while high
//   tick              time-base strobe
//   ack_num           latest remote acknowledgement number
//   add               a new entry was written at the tail this cycle
//   ptr               RAM port-B address
//   pkt_r             RAM port-B read data (1-cycle latency)
//   pkt_w, upd        RAM port-B write data and write strobe
//   free              head entry released (one-cycle pulse)
//   rtx_val/rtx_rdy   retransmission request handshake, payload rtx_pkt
//   dcn               sticky retry-limit-exceeded flag, cleared when en is low
//   busy              FSM is not idle

module tcp_vlg_tx_scan
    import tcp_vlg_pkg::*;
#(
    parameter int D               = 4,
    parameter int TIME_W          = PKT_TIME_W,
    parameter int RTO             = 1000,
    parameter int RETRANSMISSIONS = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         tick,
    input  logic [31:0]  ack_num,
    input  logic         add,
    output logic [D-1:0] ptr,
    input  tcp_pkt_t     pkt_r,
    output tcp_pkt_t     pkt_w,
    output logic         upd,
    output logic         free,
    output logic         rtx_val,
    input  logic         rtx_rdy,
    output tcp_pkt_t     rtx_pkt,
    output logic         dcn,
    output logic         busy
);

    scan_state_t       state_q, state_d;
    logic [D-1:0]      head_q, head_d;
    logic [D-1:0]      tail_q, tail_d;
    logic [D-1:0]      ptr_q, ptr_d;
    tcp_pkt_t          cur_q, cur_d;
    logic              rtxVal_q;
    logic              dcn_q, dcn_d;
    logic [TIME_W-1:0] now;
    logic              expired;
    logic              ringEmpty;

    tcp_vlg_tx_timer #(
        .TIME_W (TIME_W),
        .RTO    (RTO)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (tick),
        .tim_i     (cur_q.tim),
        .now_o     (now),
        .expired_o (expired)
    );

    assign ringEmpty = (head_q == tail_q);

    // Next-state and RAM-port logic. The pointer only moves in NEXT, so the
    // address stays put for the whole visit of one entry, including the
    // write-back cycle. Freeing is only allowed while the scan is still sitting
    // on the head, which keeps releases in order. Dropping en overrides
    // everything and parks the FSM, abandoning any pending retransmit.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q + D'(add);
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        dcn_d   = dcn_q;
        upd     = 1'b0;
        free    = 1'b0;
        pkt_w   = '0;

        case (state_q)
            ST_IDLE: begin
                if (en && !ringEmpty) begin
                    ptr_d   = head_q;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cur_d   = pkt_r;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (!cur_q.present) begin
                    state_d = ST_NEXT;
                end else if (isAcked(ack_num, cur_q)) begin
                    state_d = (ptr_q == head_q) ? ST_FREE : ST_NEXT;
                end else if (expired) begin
                    if (cur_q.tries == 4'(RETRANSMISSIONS)) begin
                        dcn_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RTX;
                    end
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_RTX: begin
                if (rtxVal_q && rtx_rdy) begin
                    cur_d.tim   = now;
                    cur_d.tries = cur_q.tries + 4'd1;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                upd     = 1'b1;
                pkt_w   = cur_q;
                state_d = ST_NEXT;
            end
            ST_FREE: begin
                upd           = 1'b1;
                free          = 1'b1;
                pkt_w         = cur_q;
                pkt_w.present = 1'b0;
                head_d        = head_q + D'(1);
                state_d       = ST_NEXT;
            end
            ST_NEXT: begin
                ptr_d = ptr_q + D'(1);
                if (ptr_d == tail_q || ringEmpty) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!en) begin
            state_d = ST_IDLE;
            dcn_d   = 1'b0;
        end
    end

    // State registers. rtx_val is a flop that tracks entry into RTX, so it is
    // high exactly while the FSM waits in RTX and drops the cycle after the
    // handshake or after en goes low; reset clears it asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            ptr_q    <= '0;
            cur_q    <= '0;
            rtxVal_q <= 1'b0;
            dcn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            rtxVal_q <= (state_d == ST_RTX);
            dcn_q    <= dcn_d;
        end
    end

    assign ptr     = ptr_q;
    assign rtx_val = rtxVal_q;
    assign rtx_pkt = cur_q;
    assign dcn     = dcn_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tcp_vlg_tx_scan.sv
// tb_tcp_vlg_tx_scan
// Self-checking bench for tcp_vlg_tx_scan. A behavioural ring model predicts,
// per scan pass, the ordered list of RAM write-backs, frees, retransmit
// handshakes and dead-connection events; a monitor pops and compares them as
// the DUT produces them.

module tb_tcp_vlg_tx_scan;
   import tcp_vlg_pkg::*;

   localparam int RTO_T   = 10;
   localparam int RETRIES = 2;

   localparam int EV_FREE  = 0;
   localparam int EV_RTX   = 1;
   localparam int EV_WRITE = 2;
   localparam int EV_DCN   = 3;

   typedef struct {
      int         kind;
      logic [3:0] idx;
      tcp_pkt_t   pkt;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        tick;
   logic [31:0] ackNum;
   logic        add;
   logic [3:0]  ptr;
   tcp_pkt_t    pktR;
   tcp_pkt_t    pktW;
   logic        upd;
   logic        free;
   logic        rtxVal;
   logic        rtxRdy = 1'b0;
   tcp_pkt_t    rtxPkt;
   logic        dcn;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   // bench-side RAM and its port-A writer
   tcp_pkt_t   mem [16];
   logic       wrEn;
   logic [3:0] wrAddr;
   tcp_pkt_t   wrData;
   int         rdyMode = 1;

   // behavioural model
   tcp_pkt_t    ringPkt[$];
   ev_t         expQ[$];
   logic [3:0]  modelHead;
   logic [15:0] modelNow;
   logic        lastDcn = 1'b0;

   tcp_vlg_tx_scan #(
      .D               (4),
      .TIME_W          (16),
      .RTO             (RTO_T),
      .RETRANSMISSIONS (RETRIES)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .tick    (tick),
      .ack_num (ackNum),
      .add     (add),
      .ptr     (ptr),
      .pkt_r   (pktR),
      .pkt_w   (pktW),
      .upd     (upd),
      .free    (free),
      .rtx_val (rtxVal),
      .rtx_rdy (rtxRdy),
      .rtx_pkt (rtxPkt),
      .dcn     (dcn),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // RAM: port A written by the bench, port B read/written by the DUT
   always @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= wrData;
      if (upd) mem[ptr] <= pktW;
      pktR <= mem[ptr];
   end
   assign add = wrEn;

   // retransmit-ready driver: forced low, random, or forced high
   always @(posedge clk) begin
      #2;
      case (rdyMode)
         0:       rtxRdy = 1'b0;
         1:       rtxRdy = ($urandom_range(0, 2) == 0);
         default: rtxRdy = 1'b1;
      endcase
   end

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic popCheck(input int kind, input string name, input tcp_pkt_t actual, input logic [3:0] actPtr);
      ev_t e;
      if (expQ.size() == 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: unexpected event, got %h at ptr %0d, expected none", name, actual, actPtr);
      end else begin
         e = expQ.pop_front();
         checkOutput({name, " kind"}, 128'(kind), 128'(e.kind));
         if (kind != EV_DCN && e.kind != EV_DCN) begin
            checkOutput({name, " data"}, 128'(actual), 128'(e.pkt));
            checkOutput({name, " ptr"}, 128'(actPtr), 128'(e.idx));
         end
      end
   endtask

   // monitor: every DUT-visible event is matched against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (upd && free) popCheck(EV_FREE, "free", pktW, ptr);
         else if (upd) popCheck(EV_WRITE, "writeBack", pktW, ptr);
         else if (free) popCheck(EV_FREE, "freeWithoutUpd", pktW, ptr);
         if (rtxVal && rtxRdy) popCheck(EV_RTX, "rtx", rtxPkt, ptr);
         if (dcn && !lastDcn) popCheck(EV_DCN, "dcn", '0, ptr);
      end
      lastDcn = dcn;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic resetModel();
      ringPkt.delete();
      expQ.delete();
      modelHead = 4'd0;
      modelNow  = 16'd0;
   endtask

   task automatic addEntry(input logic [31:0] seq, input logic [15:0] len);
      tcp_pkt_t p;
      p.present = 1'b1;
      p.seq     = seq;
      p.length  = len;
      p.tim     = modelNow;
      p.tries   = 4'd0;
      wrAddr = modelHead + 4'(ringPkt.size());
      wrData = p;
      wrEn   = 1'b1;
      step();
      wrEn = 1'b0;
      ringPkt.push_back(p);
   endtask

   task automatic doTicks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         step();
         modelNow = modelNow + 16'd1;
      end
      tick = 1'b0;
   endtask

   // One scan pass over the model ring with the current ack and time.
   task automatic predictScan();
      bit          freeing;
      int          i;
      tcp_pkt_t    p;
      ev_t         e;
      logic [31:0] diff;
      logic [15:0] age;
      freeing = 1'b1;
      i = 0;
      while (i < ringPkt.size()) begin
         p     = ringPkt[i];
         diff  = ackNum - (p.seq + 32'(p.length));
         age   = modelNow - p.tim;
         e.idx = modelHead + 4'(i);
         if (diff < 32'h8000_0000) begin
            if (freeing) begin
               e.kind = EV_FREE;
               e.pkt = p;
               e.pkt.present = 1'b0;
               expQ.push_back(e);
               ringPkt.delete(0);
               modelHead = modelHead + 4'd1;
            end else begin
               i++;
            end
         end else begin
            freeing = 1'b0;
            if (int'(age) >= RTO_T) begin
               if (int'(p.tries) == RETRIES) begin
                  e.kind = EV_DCN;
                  e.pkt = '0;
                  expQ.push_back(e);
                  break;
               end
               e.kind = EV_RTX;
               e.pkt = p;
               expQ.push_back(e);
               p.tim   = modelNow;
               p.tries = p.tries + 4'd1;
               ringPkt[i] = p;
               e.kind = EV_WRITE;
               e.pkt = p;
               expQ.push_back(e);
            end
            i++;
         end
      end
   endtask

   task automatic finishRound(input string name);
      int c;
      c = 0;
      while (expQ.size() > 0 && c < 3000) begin
         step();
         c++;
      end
      checkOutput({name, " pendingEvents"}, 128'(expQ.size()), 128'(0));
      expQ.delete();
      repeat (60) step();
      en = 1'b0;
      step();
      step();
      checkOutput({name, " busyAfterEnLow"}, 128'(busy), 128'(0));
      checkOutput({name, " rtxValAfterEnLow"}, 128'(rtxVal), 128'(0));
      checkOutput({name, " dcnAfterEnLow"}, 128'(dcn), 128'(0));
   endtask

   task automatic applyStimulus(input logic [31:0] ack, input string name);
      ackNum = ack;
      predictScan();
      en = 1'b1;
      finishRound(name);
   endtask

   task automatic waitRtxVal(input string name);
      int c;
      c = 0;
      while (!rtxVal && c < 100) begin
         step();
         c++;
      end
      checkOutput({name, " rtxValRise"}, 128'(rtxVal), 128'(1));
   endtask

   task automatic resetDut();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      resetModel();
      step();
   endtask

   initial begin
      tcp_pkt_t    expPkt;
      logic [31:0] nextSeq;
      logic [31:0] ack;
      logic [15:0] len;
      int          n;
      int          k;

      rst = 1'b1; en = 1'b0; tick = 1'b0; ackNum = '0;
      wrEn = 1'b0; wrAddr = '0; wrData = '0;
      resetModel();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step();

      $display("[TB] reset values");
      checkOutput("resetPtr", 128'(ptr), 128'(0));
      checkOutput("resetPktW", 128'(pktW), 128'(0));
      checkOutput("resetUpd", 128'(upd), 128'(0));
      checkOutput("resetFree", 128'(free), 128'(0));
      checkOutput("resetRtxVal", 128'(rtxVal), 128'(0));
      checkOutput("resetRtxPkt", 128'(rtxPkt), 128'(0));
      checkOutput("resetDcn", 128'(dcn), 128'(0));
      checkOutput("resetBusy", 128'(busy), 128'(0));

      $display("[TB] in-order acknowledge");
      addEntry(32'd100, 16'd100);
      addEntry(32'd200, 16'd100);
      addEntry(32'd300, 16'd100);
      applyStimulus(32'd400, "ackInOrder");

      $display("[TB] partial acknowledge");
      addEntry(32'd400, 16'd100);
      addEntry(32'd500, 16'd100);
      applyStimulus(32'd550, "ackPartial");

      $display("[TB] timer expiry with stalled ready");
      doTicks(10);
      ackNum = 32'd550;
      predictScan();
      rdyMode = 0;
      step();
      en = 1'b1;
      waitRtxVal("expiry");
      expPkt.present = 1'b1;
      expPkt.seq     = 32'd500;
      expPkt.length  = 16'd100;
      expPkt.tim     = 16'd0;
      expPkt.tries   = 4'd0;
      checkOutput("expirySeq", 128'(rtxPkt.seq), 128'(500));
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("expiryHold", 128'({rtxVal, rtxPkt}), 128'({1'b1, expPkt}));
      end
      rdyMode = 2;
      finishRound("expiry");
      rdyMode = 1;

      $display("[TB] retry limit");
      doTicks(10);
      applyStimulus(32'd550, "retry2");
      doTicks(10);
      applyStimulus(32'd550, "retryLimit");

      $display("[TB] abort by en and by reset");
      resetDut();
      addEntry(32'd100, 16'd100);
      ackNum = 32'd0;
      doTicks(10);
      rdyMode = 0;
      step();
      en = 1'b1;
      waitRtxVal("abortEn");
      en = 1'b0;
      step();
      checkOutput("abortEnRtxVal", 128'(rtxVal), 128'(0));
      checkOutput("abortEnBusy", 128'(busy), 128'(0));
      step();
      en = 1'b1;
      waitRtxVal("abortRst");
      #2 rst = 1'b1;
      #1;
      checkOutput("abortRstRtxVal", 128'(rtxVal), 128'(0));
      checkOutput("abortRstBusy", 128'(busy), 128'(0));
      en = 1'b0;
      step();
      rst = 1'b0;
      resetModel();
      step();
      rdyMode = 1;

      $display("[TB] sequence wrap");
      addEntry(32'hFFFF_FF80, 16'h0100);
      applyStimulus(32'h0000_0080, "seqWrap");

      $display("[TB] randomized rounds");
      nextSeq = 32'hFFFF_F000 + 32'($urandom_range(0, 4095));
      for (int r = 0; r < 40; r++) begin
         n = $urandom_range(0, 4);
         if (n > 15 - ringPkt.size()) n = 15 - ringPkt.size();
         for (int j = 0; j < n; j++) begin
            len = 16'($urandom_range(1, 600));
            addEntry(nextSeq, len);
            nextSeq = nextSeq + 32'(len);
         end
         doTicks($urandom_range(0, 14));
         k = $urandom_range(0, ringPkt.size());
         if (ringPkt.size() == 0) ack = nextSeq - 32'($urandom_range(0, 50));
         else if (k == 0) ack = ringPkt[0].seq - 32'($urandom_range(1, 50));
         else ack = ringPkt[k-1].seq + 32'(ringPkt[k-1].length) + 32'($urandom_range(0, 30));
         applyStimulus(ack, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
